// File: rtl/eth_csr_access_arb.sv
// Two-requester arbiter for the HSSI Ethernet indirect CSR port. Turns a request/ack
// handshake into held command pulses that survive the MAC-side 2-stage synchronizers.
module eth_csr_access_arb #(
    parameter int CMD_HOLD   = 8,
    parameter int GAP_CYCLES = 8,
    parameter int RD_WAIT    = 16,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        pck_cp2af_softReset,
    input  logic        req0_valid,
    input  logic        req0_wr,
    input  logic [15:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ack,
    output logic [31:0] req0_rdata,
    input  logic        req1_valid,
    input  logic        req1_wr,
    input  logic [15:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ack,
    output logic [31:0] req1_rdata,
    output logic [31:0] eth_ctrl_addr,
    output logic [31:0] eth_wr_data,
    input  logic [31:0] eth_rd_data,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [2:0] {IDLE, CMD, GAP, RDWAIT, ACK} state_t;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
    } csr_req_t;

    localparam logic [CNT_W-1:0] CMD_LD = CNT_W'(CMD_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RDW_LD = CNT_W'(RD_WAIT - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             wr_q, wr_n;
    logic             rr_ptr, rr_n, gid_n;
    logic             ack0_n, ack1_n;
    logic [31:0]      ctrl_n, wdat_n, rdata0_n, rdata1_n;
    logic             pick;
    csr_req_t         req_sel;

    // rr_ptr only breaks ties; a lone requester wins outright.
    assign pick    = (req0_valid && req1_valid) ? rr_ptr : !req0_valid;
    assign req_sel = pick ? {req1_wr, req1_addr, req1_wdata}
                          : {req0_wr, req0_addr, req0_wdata};
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge pck_cp2af_softReset) begin
        if (pck_cp2af_softReset) state <= IDLE;
        else                     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        wr_n     = wr_q;
        gid_n    = grant_id;
        rr_n     = rr_ptr;
        ctrl_n   = eth_ctrl_addr;
        wdat_n   = eth_wr_data;
        rdata0_n = req0_rdata;
        rdata1_n = req1_rdata;
        ack0_n   = 1'b0;
        ack1_n   = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    gid_n   = pick;
                    rr_n    = !pick;
                    wr_n    = req_sel.wr;
                    ctrl_n  = {14'h0, !req_sel.wr, req_sel.wr, req_sel.addr};
                    wdat_n  = req_sel.wdata;
                    cnt_n   = CMD_LD;
                    state_n = CMD;
                end
            end
            CMD: begin
                if (cnt == '0) begin
                    // Drop to zero so the MAC-side edge detector re-arms.
                    ctrl_n  = '0;
                    cnt_n   = GAP_LD;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (wr_q) begin
                        ack0_n  = !grant_id;
                        ack1_n  = grant_id;
                        state_n = ACK;
                    end else begin
                        cnt_n   = RDW_LD;
                        state_n = RDWAIT;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RDWAIT: begin
                if (cnt == '0) begin
                    if (grant_id) rdata1_n = eth_rd_data;
                    else          rdata0_n = eth_rd_data;
                    ack0_n  = !grant_id;
                    ack1_n  = grant_id;
                    state_n = ACK;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge pck_cp2af_softReset) begin
        if (pck_cp2af_softReset) begin
            cnt           <= '0;
            wr_q          <= 1'b0;
            rr_ptr        <= 1'b0;
            grant_id      <= 1'b0;
            eth_ctrl_addr <= '0;
            eth_wr_data   <= '0;
            req0_ack      <= 1'b0;
            req1_ack      <= 1'b0;
            req0_rdata    <= '0;
            req1_rdata    <= '0;
        end else begin
            cnt           <= cnt_n;
            wr_q          <= wr_n;
            rr_ptr        <= rr_n;
            grant_id      <= gid_n;
            eth_ctrl_addr <= ctrl_n;
            eth_wr_data   <= wdat_n;
            req0_ack      <= ack0_n;
            req1_ack      <= ack1_n;
            req0_rdata    <= rdata0_n;
            req1_rdata    <= rdata1_n;
        end
    end

endmodule

// File: tb/tb_eth_csr_access_arb.sv
// Bench for eth_csr_access_arb: default and minimum-timing instances checked every cycle
// against a transaction-level model (cycles since grant), plus directed scenarios.
module tb_eth_csr_access_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld  [2][2];
    logic        wr   [2][2];
    logic [15:0] addr [2][2];
    logic [31:0] wd   [2][2];
    logic        ack  [2][2];
    logic [31:0] rd   [2][2];
    logic [31:0] ctrl [2];
    logic [31:0] ewd  [2];
    logic [31:0] erd  [2];
    logic        busy [2];
    logic        gid  [2];

    int checks = 0;
    int failures = 0;
    int mode = 0;
    bit keep_vld = 1'b0;

    // Model: mk = cycles since the grant cycle (-1 when idle).
    int          mk    [2];
    logic        mg    [2];
    logic        mrr   [2];
    logic        mwr   [2];
    logic [15:0] maddr [2];
    logic [31:0] mwd   [2];
    logic [31:0] mrd   [2][2];

    always #5 clk = ~clk;

    eth_csr_access_arb u_dut0 (
        .clk(clk), .pck_cp2af_softReset(rst),
        .req0_valid(vld[0][0]), .req0_wr(wr[0][0]), .req0_addr(addr[0][0]), .req0_wdata(wd[0][0]),
        .req0_ack(ack[0][0]), .req0_rdata(rd[0][0]),
        .req1_valid(vld[0][1]), .req1_wr(wr[0][1]), .req1_addr(addr[0][1]), .req1_wdata(wd[0][1]),
        .req1_ack(ack[0][1]), .req1_rdata(rd[0][1]),
        .eth_ctrl_addr(ctrl[0]), .eth_wr_data(ewd[0]), .eth_rd_data(erd[0]),
        .busy(busy[0]), .grant_id(gid[0])
    );

    eth_csr_access_arb #(.CMD_HOLD(1), .GAP_CYCLES(1), .RD_WAIT(1)) u_dut1 (
        .clk(clk), .pck_cp2af_softReset(rst),
        .req0_valid(vld[1][0]), .req0_wr(wr[1][0]), .req0_addr(addr[1][0]), .req0_wdata(wd[1][0]),
        .req0_ack(ack[1][0]), .req0_rdata(rd[1][0]),
        .req1_valid(vld[1][1]), .req1_wr(wr[1][1]), .req1_addr(addr[1][1]), .req1_wdata(wd[1][1]),
        .req1_ack(ack[1][1]), .req1_rdata(rd[1][1]),
        .eth_ctrl_addr(ctrl[1]), .eth_wr_data(ewd[1]), .eth_rd_data(erd[1]),
        .busy(busy[1]), .grant_id(gid[1])
    );

    function automatic int hold_of(int d); return (d == 0) ? 8 : 1; endfunction
    function automatic int gap_of(int d);  return (d == 0) ? 8 : 1; endfunction
    function automatic int rdw_of(int d);  return (d == 0) ? 16 : 1; endfunction
    function automatic int lat_of(int d, logic w);
        return hold_of(d) + gap_of(d) + 1 + (w ? 0 : rdw_of(d));
    endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%08h exp=0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mk[d] = -1; mg[d] = 1'b0; mrr[d] = 1'b0; mwr[d] = 1'b0;
            maddr[d] = '0; mwd[d] = '0; mrd[d][0] = '0; mrd[d][1] = '0;
        end
    endtask

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int   L;
            logic g;
            L = lat_of(d, mwr[d]);
            if (mk[d] == L) begin
                mk[d] = -1;
            end else if (mk[d] >= 1) begin
                if (!mwr[d] && mk[d] == L - 1) mrd[d][mg[d]] = erd[d];
                mk[d]++;
            end else if (vld[d][0] || vld[d][1]) begin
                if (vld[d][0] && vld[d][1]) g = mrr[d];
                else                        g = vld[d][1];
                mg[d] = g; mrr[d] = !g;
                mwr[d] = wr[d][g]; maddr[d] = addr[d][g]; mwd[d] = wd[d][g];
                mk[d] = 1;
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            logic [31:0] ec;
            int          L;
            L  = lat_of(d, mwr[d]);
            ec = 32'h0;
            if (mk[d] >= 1 && mk[d] <= hold_of(d)) ec = {14'h0, !mwr[d], mwr[d], maddr[d]};
            chk($sformatf("d%0d_ctrl", d), ctrl[d], ec);
            chk($sformatf("d%0d_wdata", d), ewd[d], mwd[d]);
            chk($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(mk[d] >= 1));
            chk($sformatf("d%0d_gid", d), 32'(gid[d]), 32'(mg[d]));
            for (int r = 0; r < 2; r++) begin
                chk($sformatf("d%0d_ack%0d", d, r), 32'(ack[d][r]),
                    32'(mk[d] == L && int'(mg[d]) == r));
                chk($sformatf("d%0d_rdata%0d", d, r), rd[d][r], mrd[d][r]);
            end
        end
    endtask

    task automatic auto_drive();
        for (int d = 0; d < 2; d++) begin
            if (mode == 1) erd[d] = $urandom;
            for (int r = 0; r < 2; r++) begin
                if (mode == 1) begin
                    if (vld[d][r] && ack[d][r])                  vld[d][r] = 1'b0;
                    else if (vld[d][r] && $urandom_range(99) < 2)  vld[d][r] = 1'b0;
                    else if (!vld[d][r] && $urandom_range(99) < 30) vld[d][r] = 1'b1;
                    if (vld[d][r] && $urandom_range(99) < 25) begin
                        wr[d][r]   = 1'($urandom);
                        addr[d][r] = 16'($urandom);
                        wd[d][r]   = $urandom;
                    end
                end else if (ack[d][r] && !keep_vld) begin
                    vld[d][r] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        if (rst) model_reset();
        else     model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        auto_drive();
    endtask

    // Called in the grant cycle; lat counts cycles from grant to the ack pulse.
    task automatic run_txn(input int d, input int r, input logic [31:0] cmd,
                           output int lat, output int ncmd);
        lat = -1; ncmd = 0;
        for (int k = 1; k <= 200 && lat < 0; k++) begin
            tick();
            if (ctrl[d] == cmd) ncmd++;
            if (ack[d][r]) lat = k;
        end
        if (lat < 0) chk($sformatf("d%0d_r%0d_timeout", d, r), 32'h0, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, n, gi;
        logic        prev;
        logic [31:0] gseq [4];
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            erd[d] = '0;
            for (int r = 0; r < 2; r++) begin
                vld[d][r] = 1'b0; wr[d][r] = 1'b0; addr[d][r] = '0; wd[d][r] = '0;
            end
        end
        model_reset();
        repeat (3) tick();
        chk("rst_ctrl", ctrl[0], 32'h0);
        chk("rst_busy", 32'(busy[0]), 32'h0);
        chk("rst_ack0", 32'(ack[0][0]), 32'h0);
        rst = 1'b0;
        repeat (2) tick();

        // Single write
        vld[0][0] = 1'b1; wr[0][0] = 1'b1; addr[0][0] = 16'h0123; wd[0][0] = 32'hDEADBEEF;
        run_txn(0, 0, 32'h00010123, lat, n);
        chk("wr_latency", 32'(lat), 32'd17);
        chk("wr_cmd_cycles", 32'(n), 32'd8);
        chk("wr_eth_wdata", ewd[0], 32'hDEADBEEF);
        tick();

        // Single read
        erd[0] = 32'hCAFE0001;
        vld[0][1] = 1'b1; wr[0][1] = 1'b0; addr[0][1] = 16'h0040;
        run_txn(0, 1, 32'h00020040, lat, n);
        chk("rd_latency", 32'(lat), 32'd33);
        chk("rd_cmd_cycles", 32'(n), 32'd8);
        chk("rd_rdata1", rd[0][1], 32'hCAFE0001);
        chk("rd_rdata0_kept", rd[0][0], 32'h0);
        tick();

        // Address change after grant
        vld[0][0] = 1'b1; wr[0][0] = 1'b1; addr[0][0] = 16'h0010; wd[0][0] = 32'h11111111;
        n = 0; lat = -1;
        for (int k = 1; k <= 200 && lat < 0; k++) begin
            tick();
            if (k == 3) addr[0][0] = 16'h0020;
            if (ctrl[0] == 32'h00010010) n++;
            if (ack[0][0]) lat = k;
        end
        chk("fc_cmd_cycles", 32'(n), 32'd8);
        chk("fc_latency", 32'(lat), 32'd17);
        tick();

        // Reset during RDWAIT
        erd[0] = 32'h5A5A0F0F;
        vld[0][0] = 1'b1; wr[0][0] = 1'b0; addr[0][0] = 16'h0200;
        repeat (20) tick();
        rst = 1'b1; vld[0][0] = 1'b0;
        #1;
        model_reset();
        chk("mrst_busy", 32'(busy[0]), 32'h0);
        chk("mrst_ctrl", ctrl[0], 32'h0);
        chk("mrst_wdata", ewd[0], 32'h0);
        chk("mrst_rdata1", rd[0][1], 32'h0);
        check_outputs();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        erd[0] = 32'h0F0FA5A5;
        vld[0][0] = 1'b1; wr[0][0] = 1'b0; addr[0][0] = 16'h0201;
        run_txn(0, 0, 32'h00020201, lat, n);
        chk("mrst_rd_latency", 32'(lat), 32'd33);
        chk("mrst_rd_data", rd[0][0], 32'h0F0FA5A5);

        // Contention from reset
        rst = 1'b1; keep_vld = 1'b1;
        vld[0][0] = 1'b1; wr[0][0] = 1'b1; addr[0][0] = 16'h0A00; wd[0][0] = 32'hA0A0A0A0;
        vld[0][1] = 1'b1; wr[0][1] = 1'b1; addr[0][1] = 16'h0B00; wd[0][1] = 32'hB0B0B0B0;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) gseq[i] = '1;
        gi = 0;
        for (int k = 0; k < 200 && gi < 4; k++) begin
            prev = busy[0];
            tick();
            if (busy[0] && !prev) begin
                gseq[gi] = 32'(gid[0]);
                gi++;
            end
        end
        for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), gseq[i], 32'(i % 2));
        keep_vld = 1'b0;
        vld[0][0] = 1'b0; vld[0][1] = 1'b0;
        repeat (40) tick();

        // Randomized traffic on both instances
        mode = 1;
        repeat (3000) tick();
        mode = 0;
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 2; r++) vld[d][r] = 1'b0;
        repeat (40) tick();

        // Minimum timing instance
        vld[1][0] = 1'b1; wr[1][0] = 1'b1; addr[1][0] = 16'h0ABC; wd[1][0] = 32'h12345678;
        run_txn(1, 0, 32'h00010ABC, lat, n);
        chk("min_wr_latency", 32'(lat), 32'd3);
        chk("min_wr_cmd_cycles", 32'(n), 32'd1);
        tick();
        erd[1] = 32'h0BADF00D;
        vld[1][1] = 1'b1; wr[1][1] = 1'b0; addr[1][1] = 16'h0055;
        run_txn(1, 1, 32'h00020055, lat, n);
        chk("min_rd_latency", 32'(lat), 32'd4);
        chk("min_rd_cmd_cycles", 32'(n), 32'd1);
        chk("min_rd_data", rd[1][1], 32'h0BADF00D);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_csr_access_arb.md
Name: eth_csr_access_arb

Overview:
- Arbitrates and sequences accesses to the HSSI Ethernet indirect CSR port (eth_ctrl_addr / eth_wr_data / eth_rd_data).
- Two requesters share the port: requester 0 is the host MMIO path, requester 1 is the on-chip init/link-bring-up sequencer.
- Converts single request/ack transactions into the command-bit pulse protocol the MAC side expects. The MAC side sits behind 2-stage synchronizers, so the block holds each phase long enough for it to cross.

Parameters:
- CMD_HOLD, 8: cycles a command word (bit16/bit17 set) is held on eth_ctrl_addr; must be >= 1.
- GAP_CYCLES, 8: cycles eth_ctrl_addr is held at 0 after a command, so the downstream edge detector re-arms; must be >= 1.
- RD_WAIT, 16: cycles after the gap before eth_rd_data is sampled for a read; must be >= 1.
- CNT_W, 8: phase counter width; each of the three parameters must be <= 2^CNT_W.

Ports:
- clk  in  1  CSR clock.
- pck_cp2af_softReset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  host request pending; held until req0_ack.
- req0_wr  in  1  1 = write, 0 = read.
- req0_addr  in  16  Ethernet CSR address.
- req0_wdata  in  32  write data.
- req0_ack  out  1  one-cycle completion pulse.
- req0_rdata  out  32  read data; valid on the req0_ack cycle, held until the next req0 read completes.
- req1_valid, req1_wr, req1_addr, req1_wdata, req1_ack, req1_rdata: same as the req0 signals, for the init sequencer.
- eth_ctrl_addr  out  32  [15:0] address, [16] write command, [17] read command, [31:18] zero.
- eth_wr_data  out  32  write data to the MAC.
- eth_rd_data  in  32  read data from the MAC, already synchronized to clk.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  requester currently being served; held from the last grant.

Behaviour:
- Reset: asynchronous on pck_cp2af_softReset and active-high; clock clk.
- Reset values:
  - state = IDLE.
  - eth_ctrl_addr = 0, eth_wr_data = 0.
  - req0_ack = req1_ack = 0.
  - req0_rdata = req1_rdata = 0.
  - busy = 0, grant_id = 0, rr_ptr = 0, counter = 0.
- States: IDLE, CMD, GAP, RDWAIT, ACK.
- IDLE:
  - If exactly one valid is high, grant it.
  - If both are high, grant the requester rr_ptr points to, then set rr_ptr to the other requester.
  - Granting a lone requester also sets rr_ptr to the other requester.
  - On grant, latch wr, addr and wdata into internal registers. Drive eth_wr_data = wdata and eth_ctrl_addr = {14'b0, rd, wr, addr}. Load counter = CMD_HOLD-1 and go to CMD.
  - Registered outputs: eth_ctrl_addr becomes nonzero on the cycle after the grant decision.
- CMD: hold the outputs. When counter = 0, clear eth_ctrl_addr to 0 (eth_wr_data is kept), load GAP_CYCLES-1 and go to GAP. Otherwise decrement the counter.
- GAP: when counter = 0:
  - write: go to ACK.
  - read: load RD_WAIT-1 and go to RDWAIT.
  - Otherwise decrement the counter.
- RDWAIT: when counter = 0, capture eth_rd_data into the granted requester's rdata and go to ACK.
- ACK:
  - Pulse the granted requester's ack for exactly one cycle, then return to IDLE.
  - A new grant cannot occur in the ACK cycle.
  - A requester still holding valid high may be re-granted on the IDLE cycle after ACK, subject to rr_ptr.
- Latency (cycles from IDLE grant to ack):
  - write: CMD_HOLD + GAP_CYCLES + 1.
  - read: CMD_HOLD + GAP_CYCLES + RD_WAIT + 1.
  - Defaults: write 17, read 33.
- Request fields are latched at grant. Changing addr/wdata/wr afterwards has no effect on the transaction in flight.
- If valid drops before ack, the transaction still completes and the ack is still pulsed. The requester must ignore it.
- Bits 16 and 17 are never both set. eth_ctrl_addr[31:18] is always 0.
- Reset mid-transaction:
  - Aborts immediately; all outputs go to their reset values.
  - No ack is generated for the aborted transaction.
  - rdata registers are cleared.
- Only the granted requester's rdata changes. The other requester's rdata is preserved.

Test Plan:
- Write, single requester: req0 writes addr 0x0123, data 0xDEADBEEF.
  - eth_ctrl_addr = 0x00010123 for 8 cycles, then 0 for 8 cycles; eth_wr_data = 0xDEADBEEF.
  - req0_ack pulses 17 cycles after the grant.
- Read, single requester: req1 reads addr 0x0040 while eth_rd_data = 0xCAFE0001.
  - eth_ctrl_addr = 0x00020040 for 8 cycles.
  - req1_ack fires 33 cycles after the grant; req1_rdata = 0xCAFE0001; req0_rdata unchanged.
- Contention: req0 and req1 both assert valid from reset and stay high.
  - Grants alternate 0,1,0,1.
  - Neither requester waits more than one transaction; bit16 and bit17 are never both set.
- Field change after grant: req0_addr changes from 0x0010 to 0x0020 in mid-CMD.
  - eth_ctrl_addr[15:0] stays 0x0010 for the whole command phase.
- Reset mid-operation: pck_cp2af_softReset asserted during RDWAIT.
  - Outputs are 0 in the same cycle; no ack; busy = 0.
  - A fresh req0 read after reset completes normally with a 33-cycle latency.
- Parameter sweep: CMD_HOLD = 1, GAP_CYCLES = 1, RD_WAIT = 1.
  - Write ack arrives 3 cycles after the grant; read ack arrives 4 cycles after the grant; data is captured correctly.
